// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: load/store func3 codes, LSU error codes and LSU state encoding.
// Latency: none (constants, types and a combinational helper only).
// Backpressure: not applicable.
package riscv_pkg;

    // Load/store width codes (func3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // LSU error codes reported with err_valid
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_FUNC3    = 2'b11;

    // LSU state encoding
    localparam logic [1:0] LSU_IDLE = 2'd0;
    localparam logic [1:0] LSU_BUS  = 2'd1;
    localparam logic [1:0] LSU_RESP = 2'd2;

    // Request fields kept for the whole transaction
    typedef struct packed {
        logic       we;
        logic [2:0] func3;
        logic [4:0] rd;
        logic [1:0] off;
    } lsu_req_t;

    // Stores only have signed widths; loads add the unsigned byte/half forms
    function automatic logic func3_legal(input logic we, input logic [2:0] func3);
        logic ok;
        case (func3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Byte-lane steering: store byte enables/replicated data and load right-justify/mask.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs. Offset forcing applies unless RISCV_LSU_MISALIGN_TRAP_EN.
module riscv_lsu_align (
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_just
);

    logic [1:0]  off_eff;
    logic [31:0] mask;

    // Without trapping, misaligned halfword/word accesses are rounded down to natural alignment
    always_comb begin
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
        off_eff = off;
`else
        case (size)
            2'b01:   off_eff = {off[1], 1'b0};
            2'b10:   off_eff = 2'b00;
            default: off_eff = off;
        endcase
`endif
    end

    // Byte enables, replicated store data and load mask selected by access width
    always_comb begin
        be         = 4'b1111;
        wdata_lane = wdata;
        mask       = 32'hFFFF_FFFF;
        case (size)
            2'b00: begin
                be         = 4'b0001 << off_eff;
                wdata_lane = {4{wdata[7:0]}};
                mask       = 32'h0000_00FF;
            end
            2'b01: begin
                be         = 4'b0011 << off_eff;
                wdata_lane = {2{wdata[15:0]}};
                mask       = 32'h0000_FFFF;
            end
            default: begin
                be         = 4'b1111;
                wdata_lane = wdata;
                mask       = 32'hFFFF_FFFF;
            end
        endcase
    end

    // Loaded byte/half moved down to bit 0; extension is left to the register file
    assign rdata_just = (rdata >> {off_eff, 3'b000}) & mask;

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one request per handshake, drives the data bus, returns load data or an error code.
// Latency: accept at cycle 0, mem_req from cycle 1, ack in cycle k -> done/wb in k+1, ready in k+2; errors found at accept retire in cycle 1.
// Backpressure: req_ready only in IDLE; mem_req held until mem_ack or TIMEOUT. Option macro: RISCV_LSU_MISALIGN_TRAP_EN.
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_mem_wr,
    output logic [4:0]  wb_rd,
    output logic [2:0]  wb_func3,
    output logic [31:0] wb_data,
    output logic        done,
    output logic        err_valid,
    output logic [1:0]  err_code
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam bit TO_EN = (TIMEOUT != 0);

    logic [1:0]    state_q;
    logic [CW-1:0] cnt_q;
    lsu_req_t      req_q;

    logic          idle;
    logic          f3_ok;
    logic          misalign;
    logic          timeout_hit;
    logic [1:0]    a_size;
    logic [1:0]    a_off;
    logic [3:0]    a_be;
    logic [31:0]   a_wdata;
    logic [31:0]   a_rdata;

    assign idle = (state_q == LSU_IDLE);

    assign f3_ok = func3_legal(req_we, req_func3);

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    assign misalign = ((req_func3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);

    // Store steering uses the live request at accept; load extraction uses the captured request
    assign a_size = idle ? req_func3[1:0] : req_q.func3[1:0];
    assign a_off  = idle ? req_addr[1:0]  : req_q.off;

    riscv_lsu_align u_align (
        .size       (a_size),
        .off        (a_off),
        .wdata      (req_wdata),
        .rdata      (mem_rdata),
        .be         (a_be),
        .wdata_lane (a_wdata),
        .rdata_just (a_rdata)
    );

    assign req_ready = idle;
    assign mem_req   = (state_q == LSU_BUS);
    assign done      = (state_q == LSU_RESP);
    assign err_valid = done && (err_code != ERR_NONE);
    assign wb_valid  = done && !req_q.we && (err_code == ERR_NONE);
    assign wb_mem_wr = wb_valid;

    // Request FSM: capture and check in IDLE, hold the bus in BUS, retire in RESP
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= LSU_IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            err_code  <= ERR_NONE;
            wb_rd     <= '0;
            wb_func3  <= '0;
            wb_data   <= '0;
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    if (req_valid) begin
                        req_q <= '{we: req_we, func3: req_func3, rd: req_rd, off: req_addr[1:0]};
                        if (!f3_ok) begin
                            err_code <= ERR_FUNC3;
                            state_q  <= LSU_RESP;
                        end else if (misalign) begin
                            err_code <= ERR_MISALIGN;
                            state_q  <= LSU_RESP;
                        end else begin
                            cnt_q     <= '0;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= a_wdata;
                            mem_be    <= a_be;
                            state_q   <= LSU_BUS;
                        end
                    end
                end
                LSU_BUS: begin
                    if (mem_ack) begin
                        err_code <= ERR_NONE;
                        if (!req_q.we) begin
                            wb_data  <= a_rdata;
                            wb_rd    <= req_q.rd;
                            wb_func3 <= req_q.func3;
                        end
                        state_q <= LSU_RESP;
                    end else if (timeout_hit) begin
                        err_code <= ERR_TIMEOUT;
                        state_q  <= LSU_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                LSU_RESP: state_q <= LSU_IDLE;
                default:  state_q <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: directed vector table plus hand sequences for reset-in-bus and back-to-back.
// Latency: checks per-cycle timing of mem_req, done and req_ready against hand-computed cycles.
// Backpressure: exercises req_valid held high and a bus that never acks (TIMEOUT = 4).
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_func3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [4:0]  req_rd = 5'd0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        wb_valid;
    logic        wb_mem_wr;
    logic [4:0]  wb_rd;
    logic [2:0]  wb_func3;
    logic [31:0] wb_data;
    logic        done;
    logic        err_valid;
    logic [1:0]  err_code;

    int n_run = 0;
    int n_fail = 0;

    riscv_lsu #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_mem_wr(wb_mem_wr), .wb_rd(wb_rd), .wb_func3(wb_func3),
        .wb_data(wb_data), .done(done), .err_valid(err_valid), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          ack_at;        // bus cycle (1-based) in which ack is driven, 0 = never
        int          exp_req_cycles;
        int          exp_done_cyc;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [1:0]  exp_err;
        logic        exp_wb;
        logic [31:0] exp_wb_data;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run(input int idx, input vec_t v);
        int cyc;
        int req_cycles;
        int done_cyc;
        bit got_done;
        @(negedge clk);
        chk($sformatf("v%0d_ready_in", idx), req_ready, 1'b1);
        req_valid = 1'b1;
        req_we    = v.we;
        req_func3 = v.f3;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_rd    = v.rd;
        @(negedge clk);
        req_valid  = 1'b0;
        cyc        = 1;
        req_cycles = 0;
        done_cyc   = 0;
        got_done   = 1'b0;
        while (!got_done && cyc <= 30) begin
            mem_ack   = 1'b0;
            mem_rdata = 32'hDEAD_BEEF;
            if (mem_req) begin
                req_cycles++;
                if (req_cycles == 1) begin
                    chk($sformatf("v%0d_mem_addr", idx), mem_addr, v.exp_addr);
                    chk($sformatf("v%0d_mem_be", idx), mem_be, v.exp_be);
                    chk($sformatf("v%0d_mem_we", idx), mem_we, v.we);
                    if (v.we) chk($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.exp_wdata);
                end
                if (req_cycles == v.ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = v.rdata;
                end
            end
            if (done) begin
                got_done = 1'b1;
                done_cyc = cyc;
                chk($sformatf("v%0d_err_valid", idx), err_valid, v.exp_err != 2'b00);
                chk($sformatf("v%0d_err_code", idx), err_code, v.exp_err);
                chk($sformatf("v%0d_wb_valid", idx), wb_valid, v.exp_wb);
                chk($sformatf("v%0d_wb_mem_wr", idx), wb_mem_wr, v.exp_wb);
                if (v.exp_wb) begin
                    chk($sformatf("v%0d_wb_data", idx), wb_data, v.exp_wb_data);
                    chk($sformatf("v%0d_wb_rd", idx), wb_rd, v.rd);
                    chk($sformatf("v%0d_wb_func3", idx), wb_func3, v.f3);
                end
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        mem_ack = 1'b0;
        chk($sformatf("v%0d_done_seen", idx), got_done, 1'b1);
        chk($sformatf("v%0d_req_cycles", idx), req_cycles, v.exp_req_cycles);
        chk($sformatf("v%0d_done_cycle", idx), done_cyc, v.exp_done_cyc);
        @(negedge clk);
        chk($sformatf("v%0d_ready_after", idx), req_ready, 1'b1);
        chk($sformatf("v%0d_done_pulse", idx), done, 1'b0);
        chk($sformatf("v%0d_wb_pulse", idx), wb_valid, 1'b0);
        chk($sformatf("v%0d_err_hold", idx), err_code, v.exp_err);
        chk($sformatf("v%0d_req_after", idx), mem_req, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //              we    f3      addr          wdata          rd     rdata          ack rc dc exp_addr       be       exp_wdata      err    wb    wb_data
        vecs[0]  = '{1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 5'd0,  32'h0,         3, 3, 4, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 2'b00, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 3'b001, 32'h0000_2002, 32'h0,         5'd5,  32'h8001_1234, 1, 1, 2, 32'h0000_2000, 4'b1100, 32'h0,         2'b00, 1'b1, 32'h0000_8001};
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
        vecs[2]  = '{1'b0, 3'b010, 32'h0000_3001, 32'h0,         5'd7,  32'h1122_3344, 1, 0, 1, 32'h0,         4'b0000, 32'h0,         2'b01, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 3'b001, 32'h0000_1001, 32'h0000_5678, 5'd0,  32'h0,         1, 0, 1, 32'h0,         4'b0000, 32'h0,         2'b01, 1'b0, 32'h0};
`else
        vecs[2]  = '{1'b0, 3'b010, 32'h0000_3001, 32'h0,         5'd7,  32'h1122_3344, 1, 1, 2, 32'h0000_3000, 4'b1111, 32'h0,         2'b00, 1'b1, 32'h1122_3344};
        vecs[11] = '{1'b1, 3'b001, 32'h0000_1001, 32'h0000_5678, 5'd0,  32'h0,         1, 1, 2, 32'h0000_1000, 4'b0011, 32'h5678_5678, 2'b00, 1'b0, 32'h0};
`endif
        vecs[3]  = '{1'b1, 3'b011, 32'h0000_1000, 32'h0000_0001, 5'd0,  32'h0,         1, 0, 1, 32'h0,         4'b0000, 32'h0,         2'b11, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 3'b000, 32'h0000_0040, 32'h0,         5'd3,  32'h0,         0, 4, 5, 32'h0000_0040, 4'b0001, 32'h0,         2'b10, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 3'b001, 32'h0000_1002, 32'h1234_BEEF, 5'd0,  32'h0,         1, 1, 2, 32'h0000_1000, 4'b1100, 32'hBEEF_BEEF, 2'b00, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 3'b010, 32'h0000_1008, 32'hCAFE_F00D, 5'd0,  32'h0,         2, 2, 3, 32'h0000_1008, 4'b1111, 32'hCAFE_F00D, 2'b00, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 3'b100, 32'h0000_5001, 32'h0,         5'd0,  32'hAABB_CCDD, 1, 1, 2, 32'h0000_5000, 4'b0010, 32'h0,         2'b00, 1'b1, 32'h0000_00CC};
        vecs[8]  = '{1'b0, 3'b000, 32'h0000_5003, 32'h0,         5'd31, 32'h80FF_0000, 2, 2, 3, 32'h0000_5000, 4'b1000, 32'h0,         2'b00, 1'b1, 32'h0000_0080};
        vecs[9]  = '{1'b0, 3'b101, 32'h0000_6000, 32'h0,         5'd9,  32'hFFFF_7654, 1, 1, 2, 32'h0000_6000, 4'b0011, 32'h0,         2'b00, 1'b1, 32'h0000_7654};
        vecs[10] = '{1'b0, 3'b011, 32'h0000_6000, 32'h0,         5'd9,  32'h0,         1, 0, 1, 32'h0,         4'b0000, 32'h0,         2'b11, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 3'b100, 32'h0000_1000, 32'h0000_0011, 5'd0,  32'h0,         1, 0, 1, 32'h0,         4'b0000, 32'h0,         2'b11, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 3'b110, 32'h0000_1000, 32'h0,         5'd2,  32'h0,         1, 0, 1, 32'h0,         4'b0000, 32'h0,         2'b11, 1'b0, 32'h0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_be", mem_be, 4'h0);
        chk("rst_done", done, 1'b0);
        chk("rst_err_valid", err_valid, 1'b0);
        chk("rst_err_code", err_code, 2'b00);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_mem_wr", wb_mem_wr, 1'b0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_wb_rd", wb_rd, 5'd0);
        chk("rst_wb_func3", wb_func3, 3'd0);
        rst_n = 1'b1;

        // Reset asserted while the bus request is outstanding, ack arrives afterwards
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010; req_addr = 32'h0000_8000; req_rd = 5'd6;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rib_mem_req_c1", mem_req, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rib_mem_req_c2", mem_req, 1'b0);
        chk("rib_ready_c2", req_ready, 1'b1);
        chk("rib_done_c2", done, 1'b0);
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("rib_done_late", done, 1'b0);
        chk("rib_wb_late", wb_valid, 1'b0);
        chk("rib_mem_req_late", mem_req, 1'b0);
        chk("rib_ready_late", req_ready, 1'b1);

        // Directed vector table
        for (int i = 0; i < NV; i++) run(i, vecs[i]);

        // Back-to-back with req_valid held high
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010; req_addr = 32'h0000_7000; req_rd = 5'd4;
        @(negedge clk);
        chk("b2b_req_c1", mem_req, 1'b1);
        chk("b2b_addr_c1", mem_addr, 32'h0000_7000);
        chk("b2b_ready_c1", req_ready, 1'b0);
        req_addr = 32'h0000_7004;
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("b2b_done_c2", done, 1'b1);
        chk("b2b_data_c2", wb_data, 32'h0BAD_F00D);
        chk("b2b_ready_c2", req_ready, 1'b0);
        @(negedge clk);
        chk("b2b_ready_c3", req_ready, 1'b1);
        chk("b2b_req_c3", mem_req, 1'b0);
        chk("b2b_done_c3", done, 1'b0);
        @(negedge clk);
        chk("b2b_req_c4", mem_req, 1'b1);
        chk("b2b_addr_c4", mem_addr, 32'h0000_7004);
        chk("b2b_ready_c4", req_ready, 1'b0);
        req_valid = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("b2b_done_c5", done, 1'b1);
        chk("b2b_data_c5", wb_data, 32'h1234_5678);
        @(negedge clk);
        chk("b2b_ready_c6", req_ready, 1'b1);
        chk("b2b_req_c6", mem_req, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit between the execute stage and the data-memory bus. Accepts one load or store per request handshake and steers store data into byte lanes with byte enables. For loads, returns memory data right-justified and size-masked, together with `func3` and `rd`, to the register-file write port, where sign or zero extension is applied. It is the write-side counterpart of the register file's load writeback path and owns all memory-bus sequencing.

## Interface
- `TIMEOUT`, 255: bus cycles to wait for `mem_ack` before aborting; 0 disables the timeout.
- `clk` in 1: clock, all logic on rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `req_valid` in 1: execute stage presents a request.
- `req_ready` out 1: LSU idle and able to accept.
- `req_we` in 1: 1 = store, 0 = load.
- `req_func3` in 3: RISC-V load/store `func3`.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data (rs2).
- `req_rd` in 5: load destination register.
- `mem_req` out 1: bus request, held until ack or abort.
- `mem_we` out 1: bus write.
- `mem_addr` out 32: word address (`[1:0]` = 0).
- `mem_wdata` out 32: lane-steered store data.
- `mem_be` out 4: byte enables.
- `mem_ack` in 1: bus completion, one-cycle pulse.
- `mem_rdata` in 32: read word, valid with `mem_ack`.
- `wb_valid` out 1: one-cycle pulse, load result valid; drives register-file `write_enable`.
- `wb_mem_wr` out 1: equals `wb_valid`; drives register-file `mem_wr`.
- `wb_rd` out 5: load destination register.
- `wb_func3` out 3: load `func3`.
- `wb_data` out 32: right-justified, size-masked load data.
- `done` out 1: one-cycle pulse, request retired (success or error).
- `err_valid` out 1: one-cycle pulse with `done` on error.
- `err_code` out 2: 01 misaligned, 10 timeout, 11 illegal `func3`, 00 none.

## Operation
- FSM states `IDLE`, `BUS`, `RESP`. `req_ready` = (state == `IDLE`).
- `IDLE`: on `req_valid`, capture the request.
  - Illegal `func3` goes to `RESP` with error 11. Legal store `func3` values are 000, 001, 010; legal load values are 000, 001, 010, 100, 101.
  - A misaligned access goes to `RESP` with error 01. Misaligned means a halfword with `addr[0]` = 1, or a word with `addr[1:0]` ≠ 0. Only checked when the macro below is defined.
  - Otherwise go to `BUS`.
  - `mem_ack` is ignored in `IDLE`.
- `BUS`: `mem_req` = 1.
  - `mem_addr`, `mem_we`, `mem_be`, `mem_wdata` are registered and stable throughout.
  - On `mem_ack`, capture `mem_rdata` and go to `RESP`.
  - The timeout counter clears on entry and increments each cycle without ack. At `TIMEOUT` cycles, drop `mem_req` and go to `RESP` with error 10.
- `RESP`: one cycle.
  - Pulse `done`.
  - Pulse `wb_valid` for successful loads only. This includes `rd` = 0; the register file discards writes to x0.
  - Pulse `err_valid` on error; `wb_valid` = 0.
  - Return to `IDLE`.
- Store steering, with `off` = `addr[1:0]`:
  - SB: `be` = 0001<<off, `wdata` = {4{`b`}}.
  - SH: `be` = 0011<<off, `wdata` = {2{`h`}}.
  - SW: `be` = 1111, `wdata` = `req_wdata`.
- Load: `wb_data` = `mem_rdata` >> (8·off), masked to 8/16/32 bits per `func3[1:0]`. No extension is applied.

## Timing
- Reset: state `IDLE`, counter 0. All outputs are 0 except `req_ready` = 1.
- Reset in `BUS` drops `mem_req` at the next edge. A late ack is ignored.
- Accept edge at cycle 0. `mem_req` is high from cycle 1.
- Ack sampled in cycle k gives `wb_valid`/`done` in cycle k+1 and `req_ready` in cycle k+2. Minimum turnaround is 3 cycles.
- Error without bus access: `done`/`err_valid` in cycle 1 after accept; `mem_req` never asserts.
- `err_code` and `wb_*` hold their values until the next `RESP`.

## Configuration
- `RISCV_LSU_MISALIGN_TRAP_EN`:
  - Defined: misaligned accesses are rejected with error 01 and no bus access.
  - Undefined: halfword forces `addr[0]` = 0 and word forces `addr[1:0]` = 0 before steering. Code 01 is never produced.

## Structure
- Shared package `riscv_pkg` holds:
  - `func3` constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`;
  - error-code constants;
  - the LSU state encoding.
- Sub-module `riscv_lsu_align`: combinational lane steering. Produces `be`, replicated `wdata`, and the load shift/mask. It is shared by the store and load paths.

## Test plan
- SB: `addr` 0x1003, `wdata` 0x000000A5, ack after 2 cycles -> `mem_addr` 0x1000, `be` 1000, `mem_wdata` 0xA5A5A5A5, `done` pulse, `wb_valid` 0.
- LH: `addr` 0x2002, `rd` 5, `rdata` 0x8001_1234, ack in cycle 1 -> `wb_valid` cycle 2, `wb_data` 0x00008001, `wb_func3` 001, `wb_rd` 5.
- Macro defined, LW at 0x3001 -> `err_valid` with code 01 in cycle 1, `mem_req` never high. Macro undefined -> bus access to 0x3000 with `be` 1111.
- `func3` 011 store -> code 11, no bus access. `TIMEOUT` = 4, no ack -> `mem_req` high 4 cycles, then code 10.
- `rst_n` low during `BUS`, ack arrives afterwards -> `mem_req` 0 next cycle, no `done`/`wb_valid`, `req_ready` 1.
- Back-to-back requests with `req_valid` held high -> second accepted only when `req_ready` reasserts (cycle k+2).
